// File: rtl/convolution.sv
// 3x3 single-channel convolution: 8-bit unsigned pixels times 9-bit signed weights,
// three-stage pipeline (products, row sums, total + saturate) with a data_rdy flag.
module convolution (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] pixel_1,
  input  logic [7:0] pixel_2,
  input  logic [7:0] pixel_3,
  input  logic [7:0] pixel_4,
  input  logic [7:0] pixel_5,
  input  logic [7:0] pixel_6,
  input  logic [7:0] pixel_7,
  input  logic [7:0] pixel_8,
  input  logic [7:0] pixel_9,
  input  logic [8:0] kernel_1,
  input  logic [8:0] kernel_2,
  input  logic [8:0] kernel_3,
  input  logic [8:0] kernel_4,
  input  logic [8:0] kernel_5,
  input  logic [8:0] kernel_6,
  input  logic [8:0] kernel_7,
  input  logic [8:0] kernel_8,
  input  logic [8:0] kernel_9,
  output logic       data_rdy,
  output logic [7:0] data_out
);

  logic        [7:0]  pix      [9];
  logic        [8:0]  kern     [9];
  logic signed [16:0] prod_d   [9];
  logic signed [16:0] prod_q   [9];
  logic signed [18:0] row_d    [3];
  logic signed [18:0] row_q    [3];
  logic signed [20:0] sum;
  logic        [7:0]  sat;
  logic               v1_q;
  logic               v2_q;
  logic               data_rdy_q;
  logic        [7:0]  data_out_q;

  assign pix[0] = pixel_1;
  assign pix[1] = pixel_2;
  assign pix[2] = pixel_3;
  assign pix[3] = pixel_4;
  assign pix[4] = pixel_5;
  assign pix[5] = pixel_6;
  assign pix[6] = pixel_7;
  assign pix[7] = pixel_8;
  assign pix[8] = pixel_9;

  assign kern[0] = kernel_1;
  assign kern[1] = kernel_2;
  assign kern[2] = kernel_3;
  assign kern[3] = kernel_4;
  assign kern[4] = kernel_5;
  assign kern[5] = kernel_6;
  assign kern[6] = kernel_7;
  assign kern[7] = kernel_8;
  assign kern[8] = kernel_9;

  // Operands widened to 17 bits: pixel zero-extended, weight sign-extended.
  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      prod_d[i] = $signed({9'b0, pix[i]}) * $signed({{8{kern[i][8]}}, kern[i]});
    end
  end

  always_comb begin
    row_d[0] = {{2{prod_q[0][16]}}, prod_q[0]} + {{2{prod_q[1][16]}}, prod_q[1]}
             + {{2{prod_q[2][16]}}, prod_q[2]};
    row_d[1] = {{2{prod_q[3][16]}}, prod_q[3]} + {{2{prod_q[4][16]}}, prod_q[4]}
             + {{2{prod_q[5][16]}}, prod_q[5]};
    row_d[2] = {{2{prod_q[6][16]}}, prod_q[6]} + {{2{prod_q[7][16]}}, prod_q[7]}
             + {{2{prod_q[8][16]}}, prod_q[8]};
  end

  always_comb begin
    sum = {{2{row_q[0][18]}}, row_q[0]} + {{2{row_q[1][18]}}, row_q[1]}
        + {{2{row_q[2][18]}}, row_q[2]};
    if (sum[20])              sat = '0;
    else if (sum[19:8] != '0) sat = '1;
    else                      sat = sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) row_q[i]  <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      data_rdy_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int unsigned i = 0; i < 3; i++) row_q[i]  <= row_d[i];
      v1_q       <= enable;
      v2_q       <= v1_q;
      data_rdy_q <= v2_q;
      // Output holds its last result across bubbles.
      if (v2_q) data_out_q <= sat;
    end
  end

  assign data_rdy = data_rdy_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_convolution.sv
// Scoreboard bench for convolution: expected pixels queued at drive time, popped when data_rdy rises.
module tb_convolution;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic        [7:0] pixel [9];
  logic signed [8:0] kern  [9];
  logic              data_rdy;
  logic        [7:0] data_out;

  int checks = 0;
  int errors = 0;
  int exp_q [$];
  logic [2:0] vpipe = '0;
  int last_out = 0;

  always #5 clk = ~clk;

  convolution dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_1(pixel[0]), .pixel_2(pixel[1]), .pixel_3(pixel[2]),
    .pixel_4(pixel[3]), .pixel_5(pixel[4]), .pixel_6(pixel[5]),
    .pixel_7(pixel[6]), .pixel_8(pixel[7]), .pixel_9(pixel[8]),
    .kernel_1(kern[0]), .kernel_2(kern[1]), .kernel_3(kern[2]),
    .kernel_4(kern[3]), .kernel_5(kern[4]), .kernel_6(kern[5]),
    .kernel_7(kern[6]), .kernel_8(kern[7]), .kernel_9(kern[8]),
    .data_rdy(data_rdy), .data_out(data_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model();
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(pixel[i]) * int'(kern[i]);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic set_all(input int p, input int k);
    for (int i = 0; i < 9; i++) begin
      pixel[i] = 8'(p);
      kern[i]  = 9'(k);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic step(input bit en);
    enable = en;
    if (en) exp_q.push_back(model());
    vpipe = {vpipe[1:0], en};
    @(posedge clk);
    @(negedge clk);
    check("rdy", int'(data_rdy), int'(vpipe[2]));
    if (vpipe[2]) begin
      if (exp_q.size() == 0) check("underflow", 1, 0);
      else last_out = exp_q.pop_front();
    end
    check("out", int'(data_out), last_out);
  endtask

  task automatic steps(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en);
  endtask

  initial begin
    set_all(0, 0);
    #12;
    check("reset_rdy", int'(data_rdy), 0);
    check("reset_out", int'(data_out), 0);
    @(negedge clk);
    reset = 1'b1;

    // All zero window held
    steps(10, 1'b1);
    steps(3, 1'b0);

    // Sharpen kernel -> 3
    pixel[0] = 1; pixel[1] = 1; pixel[2] = 1;
    pixel[3] = 0; pixel[4] = 1; pixel[5] = 0;
    pixel[6] = 1; pixel[7] = 1; pixel[8] = 0;
    kern[0] = 0;  kern[1] = -1; kern[2] = 0;
    kern[3] = -1; kern[4] = 5;  kern[5] = -1;
    kern[6] = 0;  kern[7] = -1; kern[8] = 0;
    check("sharpen_model", model(), 3);
    steps(10, 1'b1);

    // Saturation high / low and extreme weight
    set_all(255, 1);
    steps(3, 1'b1);
    set_all(255, -1);
    steps(3, 1'b1);
    set_all(0, 0);
    pixel[4] = 255; kern[4] = -256;
    steps(3, 1'b1);
    set_all(0, 0);
    pixel[4] = 255; kern[4] = 255;
    steps(2, 1'b1);
    steps(4, 1'b0);

    // Single-cycle pulse then streaming identity windows
    set_all(0, 0);
    kern[4] = 1; pixel[4] = 77;
    step(1'b1);
    steps(4, 1'b0);
    pixel[4] = 10; step(1'b1);
    pixel[4] = 20; step(1'b1);
    pixel[4] = 30; step(1'b1);
    steps(4, 1'b0);

    // Bubble pattern 1,0,1
    pixel[4] = 50; step(1'b1);
    pixel[4] = 99; step(1'b0);
    pixel[4] = 60; step(1'b1);
    steps(4, 1'b0);

    // Random windows streamed back to back
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 9; i++) begin
        pixel[i] = 8'($urandom_range(255));
        kern[i]  = 9'($urandom_range(511));
      end
      step(($urandom_range(3) != 0));
    end
    steps(4, 1'b0);

    // Asynchronous reset with results in flight
    set_all(0, 0);
    kern[4] = 1; pixel[4] = 123;
    steps(4, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rdy", int'(data_rdy), 0);
    check("async_out", int'(data_out), 0);
    exp_q.delete();
    vpipe = '0;
    last_out = 0;
    @(negedge clk);
    reset = 1'b1;
    steps(5, 1'b0);

    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
